// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - seven-segment scan bus reader: settles, decodes and
// publishes a coherent 4-digit frame with valid/err pulses.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  AN,
  input  logic [7:0]  SEGMENT,
  output logic [15:0] HEXS,
  output logic [3:0]  POINTS,
  output logic [3:0]  BLANK,
  output logic        valid,
  output logic        err
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_ACC = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [TOUT_W-1:0] TOUT_MAX = TOUT_W'(TIMEOUT_CYCLES);
  localparam logic [TOUT_W-1:0] TOUT_HIT = TOUT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        an_q, an_p;
  logic [7:0]        seg_q, seg_p;
  logic [STAB_W-1:0] stab_cnt;
  logic [TOUT_W-1:0] tout_cnt;
  logic [3:0]        mask;
  logic [15:0]       sh_hex;
  logic [3:0]        sh_pt;
  logic [3:0]        sh_blank;

  logic        same, accept, one_low, dec_legal, dec_blank;
  logic        acc_legal, acc_illegal, commit, timeout;
  logic [3:0]  dec_nib, dig_bit, mask_set;
  logic [1:0]  dig_idx;
  logic [6:0]  lit;
  logic [15:0] sh_hex_d;
  logic [3:0]  sh_pt_d, sh_blank_d;

  // Returns {legal, blank, nibble} for a gfedcba lit pattern.
  function automatic logic [5:0] decode_lit(input logic [6:0] l);
    logic [5:0] r;
    case (l)
      7'h3F:   r = 6'b10_0000;
      7'h06:   r = 6'b10_0001;
      7'h5B:   r = 6'b10_0010;
      7'h4F:   r = 6'b10_0011;
      7'h66:   r = 6'b10_0100;
      7'h6D:   r = 6'b10_0101;
      7'h7D:   r = 6'b10_0110;
      7'h07:   r = 6'b10_0111;
      7'h7F:   r = 6'b10_1000;
      7'h6F:   r = 6'b10_1001;
      7'h77:   r = 6'b10_1010;
      7'h7C:   r = 6'b10_1011;
      7'h39:   r = 6'b10_1100;
      7'h5E:   r = 6'b10_1101;
      7'h79:   r = 6'b10_1110;
      7'h71:   r = 6'b10_1111;
      7'h00:   r = 6'b11_0000;
      default: r = 6'b00_0000;
    endcase
    return r;
  endfunction

  always_comb begin
    same    = ({an_q, seg_q} == {an_p, seg_p});
    accept  = same && (stab_cnt == STAB_ACC);
    dig_bit = ~an_q;
    one_low = (dig_bit != 4'b0000) && ((dig_bit & (dig_bit - 4'd1)) == 4'b0000);
    dig_idx = 2'd0;
    case (an_q)
      4'b1110: dig_idx = 2'd0;
      4'b1101: dig_idx = 2'd1;
      4'b1011: dig_idx = 2'd2;
      4'b0111: dig_idx = 2'd3;
      default: dig_idx = 2'd0;
    endcase
    lit = ~seg_q[6:0];
    {dec_legal, dec_blank, dec_nib} = decode_lit(lit);

    acc_legal   = accept && one_low && dec_legal;
    acc_illegal = accept && one_low && !dec_legal;

    sh_hex_d   = sh_hex;
    sh_pt_d    = sh_pt;
    sh_blank_d = sh_blank;
    mask_set   = mask;
    if (acc_legal) begin
      sh_hex_d[dig_idx*4 +: 4] = dec_nib;
      sh_pt_d[dig_idx]         = ~seg_q[7];
      sh_blank_d[dig_idx]      = dec_blank;
      mask_set                 = mask | dig_bit;
    end

    commit  = acc_legal && (mask_set == 4'hF);
    timeout = !acc_legal && (mask != 4'h0) && (tout_cnt == TOUT_HIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc_legal) state_d = commit ? COMMIT : COLLECT;
      COLLECT: begin
        if (commit)       state_d = COMMIT;
        else if (timeout) state_d = IDLE;
      end
      COMMIT:  state_d = acc_legal ? COLLECT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign valid = (state_q == COMMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q     <= 4'h0;
      seg_q    <= 8'h00;
      an_p     <= 4'h0;
      seg_p    <= 8'h00;
      stab_cnt <= '0;
      tout_cnt <= '0;
      mask     <= 4'h0;
      sh_hex   <= 16'h0000;
      sh_pt    <= 4'h0;
      sh_blank <= 4'h0;
      HEXS     <= 16'h0000;
      POINTS   <= 4'b0000;
      BLANK    <= 4'b1111;
      err      <= 1'b0;
    end else begin
      an_q  <= AN;
      seg_q <= SEGMENT;
      an_p  <= an_q;
      seg_p <= seg_q;

      if (!same)                 stab_cnt <= STAB_W'(1);
      else if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + STAB_W'(1);

      if (acc_legal || commit)       tout_cnt <= '0;
      else if (tout_cnt != TOUT_MAX) tout_cnt <= tout_cnt + TOUT_W'(1);

      sh_hex   <= sh_hex_d;
      sh_pt    <= sh_pt_d;
      sh_blank <= sh_blank_d;

      // The full mask is never stored: commit and clear happen on one edge.
      if (commit || timeout) mask <= 4'h0;
      else                   mask <= mask_set;

      if (commit) begin
        HEXS   <= sh_hex_d;
        POINTS <= sh_pt_d;
        BLANK  <= sh_blank_d;
      end

      err <= acc_illegal || timeout;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  AN;
  logic [7:0]  SEGMENT;
  logic [15:0] HEXS;
  logic [3:0]  POINTS;
  logic [3:0]  BLANK;
  logic        valid;
  logic        err;

  seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst(rst), .AN(AN), .SEGMENT(SEGMENT),
    .HEXS(HEXS), .POINTS(POINTS), .BLANK(BLANK), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] hexs;
    logic [3:0]  points;
    logic [3:0]  blank;
  } frame_t;

  frame_t sb[$];
  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int err_base;
  logic [6:0] lit_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] v, input logic p);
    return {~p, ~lit_tab[v]};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          frame_t e;
          e = sb.pop_front();
          check("hexs", {16'h0, HEXS}, {16'h0, e.hexs});
          check("points", {28'h0, POINTS}, {28'h0, e.points});
          check("blank", {28'h0, BLANK}, {28'h0, e.blank});
        end
      end
      if (err) err_seen++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input int idx, input logic [7:0] seg, input int hold);
    AN = ~(4'b0001 << idx);
    SEGMENT = seg;
    cycles(hold);
    AN = 4'hF;
    SEGMENT = 8'hFF;
    cycles(2);
  endtask

  task automatic scan(input logic [15:0] h, input logic [3:0] p);
    sb.push_back({h, p, 4'b0000});
    for (int i = 3; i >= 0; i--) send_digit(i, seg_of(h[i*4 +: 4], p[i]), 8);
    cycles(4);
  endtask

  initial begin
    rst = 1'b1;
    AN = 4'hF;
    SEGMENT = 8'hFF;
    cycles(3);
    @(negedge clk);
    check("rst_hexs", {16'h0, HEXS}, 32'h0);
    check("rst_points", {28'h0, POINTS}, 32'h0);
    check("rst_blank", {28'h0, BLANK}, 32'hF);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    cycles(1);
    rst = 1'b0;
    cycles(2);

    scan(16'h1234, 4'b0000);
    check("scan_err", err_seen, 0);

    for (int v = 0; v < 16; v++) scan({12'h000, 4'(v)}, {3'b000, ~v[0]});
    check("codes_err", err_seen, 0);

    sb.push_back({16'h5071, 4'b0000, 4'b0100});
    send_digit(3, seg_of(4'h5, 1'b0), 8);
    send_digit(2, 8'hFF, 8);
    send_digit(1, seg_of(4'h7, 1'b0), 8);
    send_digit(0, seg_of(4'h1, 1'b0), 8);
    cycles(4);

    err_base = err_seen;
    send_digit(3, seg_of(4'hA, 1'b0), 8);
    send_digit(2, seg_of(4'hB, 1'b0), 8);
    send_digit(0, seg_of(4'hD, 1'b0), 8);
    send_digit(1, 8'hFE, 8);
    cycles(4);
    check("illegal_err", err_seen - err_base, 1);
    check("illegal_no_commit", {16'h0, HEXS}, 32'h5071);
    sb.push_back({16'hABCD, 4'b0010, 4'b0000});
    send_digit(1, seg_of(4'hC, 1'b1), 8);
    cycles(4);

    send_digit(3, seg_of(4'h3, 1'b0), 8);
    send_digit(2, seg_of(4'h3, 1'b0), 8);
    send_digit(1, seg_of(4'h3, 1'b0), 8);
    send_digit(0, seg_of(4'h3, 1'b0), 3);
    cycles(10);
    check("glitch_hexs", {16'h0, HEXS}, 32'hABCD);
    rst = 1'b1;
    cycles(2);
    @(negedge clk);
    check("midrst_hexs", {16'h0, HEXS}, 32'h0);
    check("midrst_blank", {28'h0, BLANK}, 32'hF);
    check("midrst_points", {28'h0, POINTS}, 32'h0);
    cycles(1);
    rst = 1'b0;
    cycles(2);
    scan(16'h9ABC, 4'b1001);

    err_base = err_seen;
    send_digit(0, seg_of(4'h6, 1'b0), 8);
    send_digit(1, seg_of(4'h7, 1'b0), 8);
    cycles(1100);
    check("timeout_err", err_seen - err_base, 1);
    check("timeout_hexs", {16'h0, HEXS}, 32'h9ABC);
    check("timeout_points", {28'h0, POINTS}, 32'h9);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
